// File: rtl/text_screen_pkg.sv
// text_screen_pkg
// Shared constants and types for the text screen front end.
// Contents: default geometry and clear byte, control code values,
// the writer state enum, and the buffer address width.
package text_screen_pkg;

   localparam int         DEF_COLS       = 32;
   localparam int         DEF_ROWS       = 16;
   localparam logic [7:0] DEF_CLEAR_CHAR = 8'h20;

   // Text buffer address is {row, col}
   localparam int         ADDR_W         = $clog2(DEF_COLS) + $clog2(DEF_ROWS);

   localparam logic [7:0] CH_CR          = 8'h0D;
   localparam logic [7:0] CH_LF          = 8'h0A;
   localparam logic [7:0] CH_BS          = 8'h08;
   localparam logic [7:0] CH_FF          = 8'h0C;

   typedef enum logic [1:0] {
      CLEAR_ALL = 2'd0,
      IDLE      = 2'd1,
      CLEAR_ROW = 2'd2
   } state_e;

endpackage

// File: rtl/text_cursor.sv
// text_cursor
// Combinational cursor update for one accepted byte.
// Ports:
//   i_col, i_row   current cursor position
//   i_char         byte being accepted
//   o_col, o_row   cursor position after the byte
//   o_wr           the byte itself produces a buffer write
//   o_wr_col/row   position of that write
//   o_wr_data      data of that write
//   o_clr_row      byte starts a sweep of the new cursor row
//   o_clr_all      byte starts a sweep of the whole buffer
module text_cursor
   import text_screen_pkg::*;
#(
   parameter int         COLS       = DEF_COLS,
   parameter int         ROWS       = DEF_ROWS,
   parameter logic [7:0] CLEAR_CHAR = DEF_CLEAR_CHAR,
   localparam int        COL_W      = $clog2(COLS),
   localparam int        ROW_W      = $clog2(ROWS)
) (
   input  logic [COL_W-1:0] i_col,
   input  logic [ROW_W-1:0] i_row,
   input  logic [7:0]       i_char,
   output logic [COL_W-1:0] o_col,
   output logic [ROW_W-1:0] o_row,
   output logic             o_wr,
   output logic [COL_W-1:0] o_wr_col,
   output logic [ROW_W-1:0] o_wr_row,
   output logic [7:0]       o_wr_data,
   output logic             o_clr_row,
   output logic             o_clr_all
);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

   // Decode the byte into a cursor move, an optional write and a sweep request
   always_comb begin
      o_col     = i_col;
      o_row     = i_row;
      o_wr      = 1'b0;
      o_wr_col  = i_col;
      o_wr_row  = i_row;
      o_wr_data = i_char;
      o_clr_row = 1'b0;
      o_clr_all = 1'b0;
      case (i_char)
         CH_CR: begin
            o_col = {COL_W{1'b0}};
         end
         CH_LF: begin
            o_col     = {COL_W{1'b0}};
            o_row     = i_row + ROW_W'(1);
            o_clr_row = 1'b1;
         end
         CH_BS: begin
            // Backspace underflows into the end of the previous row, but
            // never past the top-left cell
            if (i_col != {COL_W{1'b0}}) begin
               o_col = i_col - COL_W'(1);
            end else if (i_row != {ROW_W{1'b0}}) begin
               o_row = i_row - ROW_W'(1);
               o_col = LAST_COL;
            end else begin
               o_col = i_col;
            end
            o_wr      = 1'b1;
            o_wr_col  = o_col;
            o_wr_row  = o_row;
            o_wr_data = CLEAR_CHAR;
         end
         CH_FF: begin
            o_col     = {COL_W{1'b0}};
            o_row     = {ROW_W{1'b0}};
            o_clr_all = 1'b1;
         end
         default: begin
            o_wr = 1'b1;
            if (i_col == LAST_COL) begin
               o_col     = {COL_W{1'b0}};
               o_row     = i_row + ROW_W'(1);
               o_clr_row = 1'b1;
            end else begin
               o_col = i_col + COL_W'(1);
            end
         end
      endcase
   end

endmodule

// File: rtl/text_console_writer.sv
// text_console_writer
// Byte-stream front end for the text screen: accepts bytes over a
// valid/ready handshake, tracks the cursor and drives the text buffer
// write port. Clears the whole buffer after reset / FF and each new row.
// Ports:
//   i_pix_clk, i_reset             clock, async active-high reset
//   i_char_valid, i_char           input byte stream
//   o_char_ready                   byte accepted this cycle when valid
//   o_wr_en, o_wr_addr, o_wr_data  text buffer write port, addr {row,col}
//   o_cursor_col, o_cursor_row     current cursor
//   o_busy                         clear sweep in progress
module text_console_writer
   import text_screen_pkg::*;
#(
   parameter int         COLS       = DEF_COLS,
   parameter int         ROWS       = DEF_ROWS,
   parameter logic [7:0] CLEAR_CHAR = DEF_CLEAR_CHAR,
   localparam int        COL_W      = $clog2(COLS),
   localparam int        ROW_W      = $clog2(ROWS),
   localparam int        AW         = COL_W + ROW_W
) (
   input  logic             i_pix_clk,
   input  logic             i_reset,
   input  logic             i_char_valid,
   input  logic [7:0]       i_char,
   output logic             o_char_ready,
   output logic             o_wr_en,
   output logic [AW-1:0]    o_wr_addr,
   output logic [7:0]       o_wr_data,
   output logic [COL_W-1:0] o_cursor_col,
   output logic [ROW_W-1:0] o_cursor_row,
   output logic             o_busy
);

   // One extra counter bit: the sweep spends one cycle at count == length
   // so that ready rises the cycle after the last sweep write is visible
   localparam int CW    = AW + 1;
   localparam int CELLS = COLS * ROWS;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             wr_en_q, wr_en_d;
   logic [AW-1:0]    wr_addr_q, wr_addr_d;
   logic [7:0]       wr_data_q, wr_data_d;

   logic [COL_W-1:0] nxt_col;
   logic [ROW_W-1:0] nxt_row;
   logic             cur_wr;
   logic [COL_W-1:0] cur_wr_col;
   logic [ROW_W-1:0] cur_wr_row;
   logic [7:0]       cur_wr_data;
   logic             cur_clr_row;
   logic             cur_clr_all;

   text_cursor #(
      .COLS       (COLS),
      .ROWS       (ROWS),
      .CLEAR_CHAR (CLEAR_CHAR)
   ) u_cursor (
      .i_col     (col_q),
      .i_row     (row_q),
      .i_char    (i_char),
      .o_col     (nxt_col),
      .o_row     (nxt_row),
      .o_wr      (cur_wr),
      .o_wr_col  (cur_wr_col),
      .o_wr_row  (cur_wr_row),
      .o_wr_data (cur_wr_data),
      .o_clr_row (cur_clr_row),
      .o_clr_all (cur_clr_all)
   );

   // Next-state, sweep counter, cursor and write-port computation
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      col_d     = col_q;
      row_d     = row_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      case (state_q)
         CLEAR_ALL: begin
            if (cnt_q == CW'(CELLS)) begin
               state_d = IDLE;
               cnt_d   = {CW{1'b0}};
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q[AW-1:0];
               wr_data_d = CLEAR_CHAR;
               cnt_d     = cnt_q + CW'(1);
            end
         end
         CLEAR_ROW: begin
            if (cnt_q == CW'(COLS)) begin
               state_d = IDLE;
               cnt_d   = {CW{1'b0}};
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = {row_q, cnt_q[COL_W-1:0]};
               wr_data_d = CLEAR_CHAR;
               cnt_d     = cnt_q + CW'(1);
            end
         end
         IDLE: begin
            if (i_char_valid) begin
               col_d = nxt_col;
               row_d = nxt_row;
               if (cur_wr) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = {cur_wr_row, cur_wr_col};
                  wr_data_d = cur_wr_data;
               end else begin
                  wr_en_d = 1'b0;
               end
               // A control code that does not write itself issues the
               // first sweep write in its own cycle; a printable byte
               // that wraps lets its own write go first
               if (cur_clr_row) begin
                  state_d = CLEAR_ROW;
                  if (cur_wr) begin
                     cnt_d = {CW{1'b0}};
                  end else begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = {nxt_row, {COL_W{1'b0}}};
                     wr_data_d = CLEAR_CHAR;
                     cnt_d     = CW'(1);
                  end
               end else if (cur_clr_all) begin
                  state_d   = CLEAR_ALL;
                  wr_en_d   = 1'b1;
                  wr_addr_d = {AW{1'b0}};
                  wr_data_d = CLEAR_CHAR;
                  cnt_d     = CW'(1);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = CLEAR_ALL;
            cnt_d   = {CW{1'b0}};
         end
      endcase
   end

   // State, counter, cursor and write-port registers
   always_ff @(posedge i_pix_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= CLEAR_ALL;
         cnt_q     <= {CW{1'b0}};
         col_q     <= {COL_W{1'b0}};
         row_q     <= {ROW_W{1'b0}};
         wr_en_q   <= 1'b0;
         wr_addr_q <= {AW{1'b0}};
         wr_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         col_q     <= col_d;
         row_q     <= row_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign o_char_ready = (state_q == IDLE);
   assign o_busy       = (state_q != IDLE);
   assign o_wr_en      = wr_en_q;
   assign o_wr_addr    = wr_addr_q;
   assign o_wr_data    = wr_data_q;
   assign o_cursor_col = col_q;
   assign o_cursor_row = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer
// Self-checking bench for text_console_writer: directed table of single
// bytes with exact next-cycle expectations, hand-written sweep sequences,
// and random byte streams checked against a cell-level reference model.
module tb_text_console_writer;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [7:0] ch;
   logic       ready;
   logic       wr_en;
   logic [8:0] wr_addr;
   logic [7:0] wr_data;
   logic [4:0] cur_col;
   logic [3:0] cur_row;
   logic       busy;

   text_console_writer dut (
      .i_pix_clk    (clk),
      .i_reset      (rst),
      .i_char_valid (valid),
      .i_char       (ch),
      .o_char_ready (ready),
      .o_wr_en      (wr_en),
      .o_wr_addr    (wr_addr),
      .o_wr_data    (wr_data),
      .o_cursor_col (cur_col),
      .o_cursor_row (cur_row),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: cursor plus queue of expected writes {addr, data}
   int m_col = 0;
   int m_row = 0;
   int exp_q[$];
   bit sb_on = 1'b0;

   typedef struct {
      logic [7:0] ch;
      bit         wr;
      logic [8:0] addr;
      logic [7:0] data;
      logic [4:0] col;
      logic [3:0] row;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void push_w(int addr, int data);
      exp_q.push_back((addr << 8) | data);
   endfunction

   function automatic void push_row_clear(int r);
      for (int c = 0; c < 32; c++) push_w(r * 32 + c, 8'h20);
   endfunction

   // Screen semantics of one accepted byte
   function automatic void model_accept(logic [7:0] b);
      case (b)
         8'h0D: m_col = 0;
         8'h0A: begin
            m_col = 0;
            m_row = (m_row + 1) % 16;
            push_row_clear(m_row);
         end
         8'h08: begin
            if (m_col > 0) m_col = m_col - 1;
            else if (m_row > 0) begin
               m_row = m_row - 1;
               m_col = 31;
            end
            push_w(m_row * 32 + m_col, 8'h20);
         end
         8'h0C: begin
            m_col = 0;
            m_row = 0;
            for (int i = 0; i < 512; i++) push_w(i, 8'h20);
         end
         default: begin
            push_w(m_row * 32 + m_col, int'(b));
            if (m_col == 31) begin
               m_col = 0;
               m_row = (m_row + 1) % 16;
               push_row_clear(m_row);
            end else begin
               m_col = m_col + 1;
            end
         end
      endcase
   endfunction

   // Scoreboard: every observed write must be the next expected one
   always @(negedge clk) begin
      if (sb_on && !rst && wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra_write: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
         end else begin
            check("sb_write", {15'd0, wr_addr, wr_data}, exp_q.pop_front());
         end
      end
   end

   // Called at a negedge; returns at a negedge with valid low
   task automatic sb_send(input logic [7:0] b);
      int n = 0;
      valid = 1'b1;
      ch    = b;
      while (ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (ready !== 1'b1) begin
         check("send_ready_timeout", 32'(n), 32'd0);
         valid = 1'b0;
         return;
      end
      model_accept(b);
      @(posedge clk);
      #1;
      check("sb_cursor", {23'd0, cur_row, cur_col}, 32'((m_row << 5) | m_col));
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || ready !== 1'b1) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("sb_drained", 32'(exp_q.size()), 32'd0);
   endtask

   // Observes a full-buffer sweep starting at the next negedge
   task automatic full_sweep(input string name);
      int err = 0;
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         if (!(wr_en === 1'b1 && wr_addr === 9'(i) && wr_data === 8'h20 && ready === 1'b0)) err++;
      end
      check(name, 32'(err), 32'd0);
      @(negedge clk);
      check({name, "_ready"}, {30'd0, ready, wr_en}, 32'h2);
      check({name, "_cursor"}, {23'd0, cur_row, cur_col}, 32'd0);
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_wr"}, {15'd0, wr_en, wr_addr, wr_data}, 32'd0);
      check({name, "_flags"}, {30'd0, ready, busy}, 32'h1);
      check({name, "_cursor"}, {23'd0, cur_row, cur_col}, 32'd0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int r;
      int err;
      logic [7:0] b;

      tbl[0] = '{8'h41, 1'b1, 9'h000, 8'h41, 5'd1,  4'd0};
      tbl[1] = '{8'h42, 1'b1, 9'h001, 8'h42, 5'd2,  4'd0};
      tbl[2] = '{8'h0D, 1'b0, 9'h000, 8'h00, 5'd0,  4'd0};
      tbl[3] = '{8'h08, 1'b1, 9'h000, 8'h20, 5'd0,  4'd0};
      tbl[4] = '{8'h0A, 1'b1, 9'h020, 8'h20, 5'd0,  4'd1};
      tbl[5] = '{8'h08, 1'b1, 9'h01F, 8'h20, 5'd31, 4'd0};
      tbl[6] = '{8'h78, 1'b1, 9'h01F, 8'h78, 5'd0,  4'd1};
      tbl[7] = '{8'h0C, 1'b1, 9'h000, 8'h20, 5'd0,  4'd0};

      rst   = 1'b1;
      valid = 1'b0;
      ch    = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      full_sweep("power_on_clear");

      // Table: one byte each, exact write in the cycle after acceptance
      sb_on = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n = 0;
         while (ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
         end
         valid = 1'b1;
         ch    = tbl[i].ch;
         model_accept(tbl[i].ch);
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_cursor", i), {23'd0, cur_row, cur_col}, {23'd0, tbl[i].row, tbl[i].col});
         @(negedge clk);
         valid = 1'b0;
         check($sformatf("tbl%0d_wr_en", i), {31'd0, wr_en}, {31'd0, tbl[i].wr});
         if (tbl[i].wr) check($sformatf("tbl%0d_wr", i), {15'd0, wr_addr, wr_data}, {15'd0, tbl[i].addr, tbl[i].data});
      end
      drain();

      // "AB" back to back: writes on consecutive cycles
      valid = 1'b1;
      ch    = 8'h41;
      model_accept(8'h41);
      @(negedge clk);
      check("ab_first", {14'd0, ready, wr_en, wr_addr, wr_data}, {14'd0, 2'b11, 9'h000, 8'h41});
      ch = 8'h42;
      model_accept(8'h42);
      @(negedge clk);
      valid = 1'b0;
      check("ab_second", {15'd0, wr_en, wr_addr, wr_data}, {15'd0, 1'b1, 9'h001, 8'h42});
      check("ab_cursor", {23'd0, cur_row, cur_col}, {23'd0, 4'd0, 5'd2});
      drain();

      // Fill row 15 and wrap to row 0
      sb_send(8'h0D);
      for (int i = 0; i < 15; i++) sb_send(8'h0A);
      for (int i = 0; i < 32; i++) sb_send(8'h61 + 8'(i % 26));
      drain();
      check("wrap_cursor", {23'd0, cur_row, cur_col}, 32'd0);

      // BS at (3,0) lands on (2,31)
      for (int i = 0; i < 3; i++) sb_send(8'h0A);
      sb_send(8'h08);
      check("bs_underflow_cursor", {23'd0, cur_row, cur_col}, {23'd0, 4'd2, 5'd31});
      drain();

      // CR at col 10, LF on row 4
      sb_send(8'h0A);
      sb_send(8'h0A);
      for (int i = 0; i < 10; i++) sb_send(8'h6B);
      check("col10_cursor", {23'd0, cur_row, cur_col}, {23'd0, 4'd4, 5'd10});
      sb_send(8'h0D);
      check("cr_cursor", {23'd0, cur_row, cur_col}, {23'd0, 4'd4, 5'd0});
      sb_send(8'h0A);
      check("lf_cursor", {23'd0, cur_row, cur_col}, {23'd0, 4'd5, 5'd0});
      drain();

      // Random stream against the reference model
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 60) b = 8'($urandom_range(8'h21, 8'h7E));
         else if (r < 70) b = 8'h0D;
         else if (r < 80) b = 8'h0A;
         else if (r < 97) b = 8'h08;
         else b = 8'h0C;
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         sb_send(b);
      end
      drain();

      // FF held during a row sweep, then reset in the middle of the full sweep
      sb_on = 1'b0;
      r = (m_row + 1) % 16;
      valid = 1'b1;
      ch    = 8'h0A;
      @(negedge clk);
      ch = 8'h0C;
      n  = 0;
      while (ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("row_sweep_busy_cycles", 32'(n), 32'd32);
      check("ff_held_cursor", {23'd0, cur_row, cur_col}, 32'(r << 5));
      @(posedge clk);
      #1;
      valid = 1'b0;
      check("ff_cursor", {23'd0, cur_row, cur_col}, 32'd0);
      err = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!(wr_en === 1'b1 && wr_addr === 9'(k) && wr_data === 8'h20)) err++;
      end
      check("ff_sweep_first100", 32'(err), 32'd0);
      rst = 1'b1;
      #1;
      check_reset_values("mid_sweep_reset");
      @(negedge clk);
      rst = 1'b0;
      full_sweep("restart_clear");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
